mpadder_seq: RTL and testbench

- Multi-cycle, limb-serial multi-precision adder/subtractor and parametrised successor of the single-cycle mpadder4.
- Processes LIMB bits per clock with a registered carry chain, trading latency for a short critical path at any operand WIDTH.
- Uses a start/done handshake so the Montgomery and exponentiation datapaths can share one instance.
- Supports add and subtract (a - b) modes and returns a WIDTH+1-bit result.

---
 rtl/mpadder_seq.sv | 109 ++++++++++
 tb/tb_mpadder_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpadder_seq.sv
// Limb-serial multi-precision adder/subtractor: result = a+b or a-b, mod 2^(WIDTH+1).
// Latency NUM_LIMBS cycles from the accepting start edge to the done pulse.
// No backpressure: start is accepted only while idle and ignored while busy.
// Ports: clk/resetn (sync active-low); start/subtract/in_a/in_b request inputs;
//        result (WIDTH+1 bits, valid from done until the next accepted start), done pulse, busy.
module mpadder_seq #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  // ceil((WIDTH+1)/LIMB)
  localparam int NUM_LIMBS = (WIDTH + LIMB) / LIMB;
  localparam int TOT       = NUM_LIMBS * LIMB;
  localparam int CW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TOT-1:0]  a_q, a_d;
  logic [TOT-1:0]  b_q, b_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  result_q, result_d;
  logic            done_q, done_d;
  logic [LIMB:0]   sum;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    // One limb of the carry chain; the operands are shifted so the active limb is always at bit 0.
    sum = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = TOT'(in_a);
          // Subtraction as a + ~b + 1: invert the zero-extended b and seed the carry with 1.
          b_d     = subtract ? ~TOT'(in_b) : TOT'(in_b);
          carry_d = subtract;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Write the limb in place; padding bits above WIDTH in the top limb are dropped.
        for (int j = 0; j < LIMB; j++) begin
          if (int'(cnt_q) * LIMB + j <= WIDTH) begin
            result_d[int'(cnt_q) * LIMB + j] = sum[j];
          end
        end
        carry_d = sum[LIMB];
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_LIMBS - 1)) begin
          // Carry out of the top limb is intentionally not kept.
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_mpadder_seq.sv
// Scoreboard bench for mpadder_seq across four limb configurations sharing one clock/reset.
// Expected results come from plain wide arithmetic at the accepting edge; a monitor pops on done.
// Checks result, start-to-done latency, busy low at done, reset behaviour and spurious done pulses.
module tb_mpadder_seq;

  localparam int N0 = 9;    // WIDTH=1027, LIMB=128
  localparam int N1 = 3;    // WIDTH=8,    LIMB=4
  localparam int N2 = 147;  // WIDTH=1027, LIMB=7
  localparam int N3 = 1;    // WIDTH=1027, LIMB=1028

  typedef struct {
    logic [1027:0] res;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [3:0]    st;
  logic          sub;
  logic [1026:0] in_a, in_b;
  logic [1027:0] result0, result2, result3;
  logic [8:0]    result1;
  logic [3:0]    done_v, busy_v;

  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  int   fr[4];
  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t e0, e1, e2, e3;

  always #5 clk = ~clk;

  mpadder_seq #(.WIDTH(1027), .LIMB(128)) d0 (
    .clk(clk), .resetn(resetn), .start(st[0]), .subtract(sub), .in_a(in_a), .in_b(in_b),
    .result(result0), .done(done_v[0]), .busy(busy_v[0]));
  mpadder_seq #(.WIDTH(8), .LIMB(4)) d1 (
    .clk(clk), .resetn(resetn), .start(st[1]), .subtract(sub), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .result(result1), .done(done_v[1]), .busy(busy_v[1]));
  mpadder_seq #(.WIDTH(1027), .LIMB(7)) d2 (
    .clk(clk), .resetn(resetn), .start(st[2]), .subtract(sub), .in_a(in_a), .in_b(in_b),
    .result(result2), .done(done_v[2]), .busy(busy_v[2]));
  mpadder_seq #(.WIDTH(1027), .LIMB(1028)) d3 (
    .clk(clk), .resetn(resetn), .start(st[3]), .subtract(sub), .in_a(in_a), .in_b(in_b),
    .result(result3), .done(done_v[3]), .busy(busy_v[3]));

  function automatic logic [1027:0] ref_w(input logic s, input logic [1026:0] a, input logic [1026:0] b);
    return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  function automatic logic [1027:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    return 1028'(r);
  endfunction

  function automatic logic [1026:0] rnd();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[1026:0];
  endfunction

  function automatic void chk(input string name, input logic [1027:0] act, input logic [1027:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s_done: done pulsed with no operation outstanding, expected no pulse", name);
  endfunction

  function automatic int qsz(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic int nl(input int d);
    case (d)
      0: return N0;
      1: return N1;
      2: return N2;
      default: return N3;
    endcase
  endfunction

  // Reference occupancy: a request is taken when the unit is free; it is free again one edge after done.
  always @(posedge clk) begin
    ecnt++;
    if (!resetn) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      for (int i = 0; i < 4; i++) fr[i] = ecnt + 1;
    end else begin
      if (st[0] && ecnt >= fr[0]) begin q0.push_back('{ref_w(sub, in_a, in_b), ecnt}); fr[0] = ecnt + N0 + 1; end
      if (st[1] && ecnt >= fr[1]) begin q1.push_back('{ref8(sub, in_a[7:0], in_b[7:0]), ecnt}); fr[1] = ecnt + N1 + 1; end
      if (st[2] && ecnt >= fr[2]) begin q2.push_back('{ref_w(sub, in_a, in_b), ecnt}); fr[2] = ecnt + N2 + 1; end
      if (st[3] && ecnt >= fr[3]) begin q3.push_back('{ref_w(sub, in_a, in_b), ecnt}); fr[3] = ecnt + N3 + 1; end
    end
  end

  always @(negedge clk) if (done_v[0]) begin
    if (q0.size() == 0) spurious("d0");
    else begin
      e0 = q0.pop_front();
      chk("d0_result", result0, e0.res);
      chk("d0_latency", 1028'(ecnt - e0.acc), 1028'(N0));
      chk("d0_busy_at_done", 1028'(busy_v[0]), '0);
    end
  end

  always @(negedge clk) if (done_v[1]) begin
    if (q1.size() == 0) spurious("d1");
    else begin
      e1 = q1.pop_front();
      chk("d1_result", 1028'(result1), e1.res);
      chk("d1_latency", 1028'(ecnt - e1.acc), 1028'(N1));
      chk("d1_busy_at_done", 1028'(busy_v[1]), '0);
    end
  end

  always @(negedge clk) if (done_v[2]) begin
    if (q2.size() == 0) spurious("d2");
    else begin
      e2 = q2.pop_front();
      chk("d2_result", result2, e2.res);
      chk("d2_latency", 1028'(ecnt - e2.acc), 1028'(N2));
      chk("d2_busy_at_done", 1028'(busy_v[2]), '0);
    end
  end

  always @(negedge clk) if (done_v[3]) begin
    if (q3.size() == 0) spurious("d3");
    else begin
      e3 = q3.pop_front();
      chk("d3_result", result3, e3.res);
      chk("d3_latency", 1028'(ecnt - e3.acc), 1028'(N3));
      chk("d3_busy_at_done", 1028'(busy_v[3]), '0);
    end
  end

  task automatic drain(input int d, input int bound);
    int n;
    n = 0;
    while (qsz(d) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsz(d) != 0) begin
      errors++;
      $display("FAIL d%0d_timeout: %0d ops outstanding after %0d cycles, expected 0", d, qsz(d), bound);
    end
  endtask

  task automatic run_op(input int d, input logic s, input logic [1026:0] a, input logic [1026:0] b);
    @(negedge clk);
    sub = s; in_a = a; in_b = b;
    st = '0; st[d] = 1'b1;
    @(negedge clk);
    st = '0;
    // Inputs move while the operation runs; they must not disturb it.
    sub = ~s; in_a = rnd(); in_b = rnd();
    drain(d, 2 * nl(d) + 10);
  endtask

  task automatic rand_op(input int d);
    logic [1026:0] a, b;
    a = rnd(); b = rnd();
    case ($urandom_range(0, 4))
      1: b = a;
      2: a = '1;
      3: b = '0;
      4: a = '0;
      default: ;
    endcase
    run_op(d, 1'($urandom_range(0, 1)), a, b);
  endtask

  initial begin
    resetn = 1'b0; st = '0; sub = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    chk("d0_reset_result", result0, '0);
    chk("d1_reset_result", 1028'(result1), '0);
    chk("d2_reset_result", result2, '0);
    chk("d3_reset_result", result3, '0);
    chk("reset_busy", 1028'(busy_v), '0);
    chk("reset_done", 1028'(done_v), '0);
    resetn = 1'b1;

    // Small configuration: directed corner cases, then random.
    run_op(1, 1'b0, 1027'h0FF, 1027'h001);
    run_op(1, 1'b1, 1027'h000, 1027'h001);
    run_op(1, 1'b1, 1027'h080, 1027'h07F);
    run_op(1, 1'b0, 1027'h000, 1027'h000);
    for (int i = 0; i < 200; i++) rand_op(1);

    // Default configuration.
    for (int i = 0; i < 200; i++) rand_op(0);

    // start held high: accepted at the first edge and then every NUM_LIMBS+1 edges.
    @(negedge clk);
    st[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_a = rnd(); in_b = rnd(); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    st = '0;
    drain(0, 40);

    // Reset during RUN aborts without a done pulse.
    @(negedge clk);
    sub = 1'b0; in_a = rnd(); in_b = rnd(); st[0] = 1'b1;
    @(negedge clk);
    st = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_result", result0, '0);
    chk("abort_busy", 1028'(busy_v[0]), '0);
    resetn = 1'b1;
    repeat (2 * N0) @(negedge clk);
    run_op(0, 1'b0, 1027'd1, 1027'd1);

    // Partial top limb and single-limb configurations.
    for (int i = 0; i < 100; i++) rand_op(2);
    for (int i = 0; i < 200; i++) rand_op(3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
